store_buffer: RTL and testbench

- Sits between the store-data formatter (SB/SH/SW operand sizing) and the data-memory write port.
- Aligns each store onto the 32-bit word and produces byte enables.
- Queues up to DEPTH committed stores and drains them to memory over a valid/ready handshake.
- Gives the load path a hazard indication when a pending store targets the same word.

---
 rtl/store_pkg.sv | 16 +
 rtl/store_align.sv | 45 ++++
 rtl/store_buffer.sv | 122 ++++++++++++
 tb/tb_store_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store buffer: funct3 encodings and the queued entry format.
package store_pkg;

   localparam int SB_AW = 32;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef struct packed {
      logic [SB_AW-3:0] word_addr;
      logic [31:0]      wdata;
      logic [3:0]       be;
   } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Lane alignment of a formatted store onto the 32-bit word, with legality of the size/offset pair.
module store_align
   import store_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic [AW-1:0] st_addr,
   input  logic [31:0]   st_data,
   input  logic [2:0]    st_funct3,
   output sb_entry_t     entry,
   output logic          legal
);

   logic [1:0] off;

   assign off = st_addr[1:0];

   // Narrow stores replicate their data across all lanes so the byte enables alone pick the target bytes.
   always_comb begin
      entry           = '0;
      legal           = 1'b0;
      entry.word_addr = (SB_AW-2)'(st_addr[AW-1:2]);
      case (st_funct3)
         F3_SB: begin
            legal       = 1'b1;
            entry.be    = 4'b0001 << off;
            entry.wdata = {4{st_data[7:0]}};
         end
         F3_SH: begin
            legal       = ~off[0];
            entry.be    = off[1] ? 4'b1100 : 4'b0011;
            entry.wdata = {2{st_data[15:0]}};
         end
         F3_SW: begin
            legal       = (off == 2'b00);
            entry.be    = 4'b1111;
            entry.wdata = st_data;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// FIFO of committed stores draining to the data-memory write port, with a same-word hazard flag for loads.
module store_buffer
   import store_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [AW-1:0]            st_addr,
   input  logic [31:0]              st_data,
   input  logic [2:0]               st_funct3,
   output logic                     st_err,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [AW-3:0]            mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_be,
   input  logic [AW-1:0]            ld_addr,
   output logic                     ld_hazard,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sb_entry_t         entries_q [DEPTH];
   sb_entry_t         alignEntry;
   sb_entry_t         headEntry;
   logic              alignLegal;
   logic [PW-1:0]     wrPtr_q, wrPtr_d;
   logic [PW-1:0]     rdPtr_q, rdPtr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              stErr_q, stErr_d;
   logic              accept, enq, deq;
   logic [1:0]        unusedLdOff;

   store_align #(
      .AW (AW)
   ) u_align (
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_funct3 (st_funct3),
      .entry     (alignEntry),
      .legal     (alignLegal)
   );

   assign st_ready  = (count_q != CW'(DEPTH));
   assign accept    = st_valid && st_ready;
   assign enq       = accept && alignLegal;
   assign mem_valid = (count_q != '0);
   assign deq       = mem_valid && mem_ready;

   // Pointers wrap naturally on a power-of-two depth; count alone tells full from empty.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      stErr_d = accept && !alignLegal;
      if (enq) begin
         wrPtr_d = wrPtr_q + PW'(1);
      end
      if (deq) begin
         rdPtr_d = rdPtr_q + PW'(1);
      end
      if (enq && !deq) begin
         count_d = count_q + CW'(1);
      end else if (!enq && deq) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         stErr_q <= 1'b0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         stErr_q <= stErr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else if (enq) begin
         entries_q[wrPtr_q] <= alignEntry;
      end
   end

   assign headEntry = entries_q[rdPtr_q];
   assign mem_addr  = (AW-2)'(headEntry.word_addr);
   assign mem_wdata = headEntry.wdata;
   assign mem_be    = mem_valid ? headEntry.be : 4'b0000;
   assign st_err    = stErr_q;
   assign count     = count_q;

   assign unusedLdOff = ld_addr[1:0];

   // A slot is live when its distance from the head is below the occupancy.
   always_comb begin
      logic [PW-1:0] slotOff;
      ld_hazard = 1'b0;
      slotOff   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slotOff = PW'(i) - rdPtr_q;
         if ((CW'(slotOff) < count_q) &&
             (entries_q[i].word_addr == (SB_AW-2)'(ld_addr[AW-1:2]))) begin
            ld_hazard = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue-based model checked every cycle plus hand-computed literal pins.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;

   typedef struct {
      logic [29:0] wa;
      logic [31:0] wd;
      logic [3:0]  be;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_funct3;
   logic        st_err;
   logic        mem_valid;
   logic        mem_ready;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic [2:0]  count;

   int   errors = 0;
   int   checks = 0;
   bit   checkEn = 1'b0;
   ent_t modelQ[$];
   bit   expErr = 1'b0;

   store_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_funct3 (st_funct3),
      .st_err    (st_err),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .ld_addr   (ld_addr),
      .ld_hazard (ld_hazard),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelAlign(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [2:0] f3, output bit legal,
                                      output logic [3:0] be, output logic [31:0] wd);
      legal = 1'b0;
      be    = 4'h0;
      wd    = 32'h0;
      case (f3)
         3'b000: begin
            legal = 1'b1;
            be    = 4'(1 << addr[1:0]);
            wd    = {4{data[7:0]}};
         end
         3'b001: begin
            legal = (addr[0] == 1'b0);
            be    = addr[1] ? 4'hC : 4'h3;
            wd    = {2{data[15:0]}};
         end
         3'b010: begin
            legal = (addr[1:0] == 2'b00);
            be    = 4'hF;
            wd    = data;
         end
         default: legal = 1'b0;
      endcase
   endfunction

   function automatic bit modelHazard(input logic [31:0] la);
      bit hit = 1'b0;
      foreach (modelQ[i]) begin
         if (modelQ[i].wa == la[31:2]) hit = 1'b1;
      end
      return hit;
   endfunction

   // Reference queue: pop the head on a ready drain, then append a legal accepted store.
   bit          mLegal;
   logic [3:0]  mBe;
   logic [31:0] mWd;
   bit          mAcc;
   ent_t        mEnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         modelQ.delete();
         expErr = 1'b0;
      end else begin
         mAcc = st_valid && (modelQ.size() != DEPTH);
         modelAlign(st_addr, st_data, st_funct3, mLegal, mBe, mWd);
         if (modelQ.size() != 0 && mem_ready) void'(modelQ.pop_front());
         if (mAcc && mLegal) begin
            mEnt.wa = st_addr[31:2];
            mEnt.wd = mWd;
            mEnt.be = mBe;
            modelQ.push_back(mEnt);
         end
         expErr = mAcc && !mLegal;
      end
   end

   always @(negedge clk) begin
      if (checkEn && !rst) begin
         checkOutput("count", 32'(count), 32'(modelQ.size()));
         checkOutput("mem_valid", 32'(mem_valid), 32'(modelQ.size() != 0));
         checkOutput("st_ready", 32'(st_ready), 32'(modelQ.size() != DEPTH));
         checkOutput("st_err", 32'(st_err), 32'(expErr));
         checkOutput("ld_hazard", 32'(ld_hazard), 32'(modelHazard(ld_addr)));
         if (modelQ.size() != 0) begin
            checkOutput("mem_be", 32'(mem_be), 32'(modelQ[0].be));
            checkOutput("mem_addr", 32'(mem_addr), 32'(modelQ[0].wa));
            checkOutput("mem_wdata", mem_wdata, modelQ[0].wd);
         end else begin
            checkOutput("mem_be_empty", 32'(mem_be), 32'h0);
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f3, input logic mr, input logic [31:0] la);
      st_valid  = v;
      st_addr   = a;
      st_data   = d;
      st_funct3 = f3;
      mem_ready = mr;
      ld_addr   = la;
      @(posedge clk);
      #2;
   endtask

   initial begin
      st_valid  = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      st_funct3 = '0;
      mem_ready = 1'b0;
      ld_addr   = '0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_count", 32'(count), 32'h0);
      checkOutput("rst_mem_valid", 32'(mem_valid), 32'h0);
      checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
      checkOutput("rst_st_err", 32'(st_err), 32'h0);
      rst     = 1'b0;
      checkEn = 1'b1;

      $display("[TB] single SB with ready memory");
      applyStimulus(1, 32'h1003, 32'h000000AB, 3'b000, 1, 32'h0);
      checkOutput("lit_sb_valid", 32'(mem_valid), 32'h1);
      checkOutput("lit_sb_addr", 32'(mem_addr), 32'h400);
      checkOutput("lit_sb_be", 32'(mem_be), 32'h8);
      checkOutput("lit_sb_wdata", mem_wdata, 32'hABABABAB);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h0);
      checkOutput("lit_sb_drained", 32'(count), 32'h0);

      $display("[TB] SH then SW, stalled then drained");
      applyStimulus(1, 32'h2002, 32'h0000BEEF, 3'b001, 0, 32'h0);
      applyStimulus(1, 32'h3000, 32'h12345678, 3'b010, 0, 32'h0);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 0, 32'h0);
      checkOutput("lit_sh_count", 32'(count), 32'h2);
      checkOutput("lit_sh_be", 32'(mem_be), 32'hC);
      checkOutput("lit_sh_wdata", mem_wdata, 32'hBEEFBEEF);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h0);
      checkOutput("lit_sw_be", 32'(mem_be), 32'hF);
      checkOutput("lit_sw_wdata", mem_wdata, 32'h12345678);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h0);

      $display("[TB] fill to full, stall, wrap");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), 3'b010, 0, 32'h0);
      end
      checkOutput("lit_full_count", 32'(count), 32'h4);
      checkOutput("lit_full_ready", 32'(st_ready), 32'h0);
      applyStimulus(1, 32'h110, 32'hA0000004, 3'b010, 0, 32'h0);
      checkOutput("lit_full_hold", 32'(count), 32'h4);
      applyStimulus(1, 32'h110, 32'hA0000004, 3'b010, 1, 32'h0);
      checkOutput("lit_full_deq", 32'(count), 32'h3);
      checkOutput("lit_full_head", 32'(mem_addr), 32'h41);
      applyStimulus(1, 32'h110, 32'hA0000004, 3'b010, 0, 32'h0);
      checkOutput("lit_wrap_count", 32'(count), 32'h4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h0);
      end
      checkOutput("lit_wrap_last", 32'(mem_addr), 32'h44);
      checkOutput("lit_wrap_data", mem_wdata, 32'hA0000004);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h0);

      $display("[TB] byte and half lanes");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 32'h800 + 32'(i), 32'(8'h11 * (i + 1)), 3'b000, 1, 32'h0);
      end
      applyStimulus(1, 32'h900, 32'hFFFF1234, 3'b001, 1, 32'h0);
      checkOutput("lit_sh_lo_be", 32'(mem_be), 32'h3);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h0);

      $display("[TB] illegal requests");
      applyStimulus(1, 32'h1001, 32'h0, 3'b001, 0, 32'h0);
      checkOutput("lit_err_sh", 32'(st_err), 32'h1);
      applyStimulus(1, 32'h1002, 32'h0, 3'b010, 0, 32'h0);
      checkOutput("lit_err_sw", 32'(st_err), 32'h1);
      applyStimulus(1, 32'h1000, 32'h0, 3'b100, 0, 32'h0);
      checkOutput("lit_err_f3", 32'(st_err), 32'h1);
      checkOutput("lit_err_count", 32'(count), 32'h0);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 0, 32'h0);
      checkOutput("lit_err_clear", 32'(st_err), 32'h0);

      $display("[TB] load hazard");
      applyStimulus(1, 32'h5004, 32'h55667788, 3'b010, 0, 32'h5006);
      checkOutput("lit_haz_hit", 32'(ld_hazard), 32'h1);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 0, 32'h5008);
      checkOutput("lit_haz_miss", 32'(ld_hazard), 32'h0);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h5006);
      checkOutput("lit_haz_drained", 32'(ld_hazard), 32'h0);

      $display("[TB] async reset with entries pending");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 32'h600 + 32'(4 * i), 32'hB0 + 32'(i), 3'b010, 0, 32'h0);
      end
      st_valid = 1'b0;
      rst      = 1'b1;
      #1;
      checkOutput("lit_arst_valid", 32'(mem_valid), 32'h0);
      checkOutput("lit_arst_count", 32'(count), 32'h0);
      checkOutput("lit_arst_be", 32'(mem_be), 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #2;
      applyStimulus(1, 32'h700, 32'hCAFE0000, 3'b010, 0, 32'h0);
      checkOutput("lit_post_count", 32'(count), 32'h1);
      checkOutput("lit_post_addr", 32'(mem_addr), 32'h1C0);
      checkOutput("lit_post_wdata", mem_wdata, 32'hCAFE0000);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 1, 32'h0);
      applyStimulus(0, 32'h0, 32'h0, 3'b000, 0, 32'h0);

      @(negedge clk);
      #1;
      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
